// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 32-bit single-cycle ALU: runs single-pass ops once
// and iterates 1-bit shift/rotate ops Shamt times, with valid/ready request and response.
module alu_seq_ctrl #(
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [31:0]        ReqA,
  input  logic [31:0]        ReqB,
  input  logic [3:0]         ReqOp,
  input  logic [SHAMT_W-1:0] ReqShamt,
  output logic               RspValid,
  input  logic               RspReady,
  output logic [31:0]        RspOut,
  output logic               RspZero,
  output logic               RspErr,
  output logic               Busy,
  output logic [31:0]        AluA,
  output logic [31:0]        AluB,
  output logic [3:0]         AluOp,
  input  logic [31:0]        AluOut,
  input  logic               AluZero
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t               state, next_state;
  logic [31:0]          a_reg, b_reg, acc;
  logic [3:0]           op_reg;
  logic [SHAMT_W-1:0]   cnt;
  logic                 accept, req_single, req_shift;

  function automatic logic is_single(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return op inside {4'b1000, 4'b1010, 4'b1001, 4'b1100, 4'b1101};
  endfunction

  assign req_single = is_single(ReqOp);
  assign req_shift  = is_shift(ReqOp);
  assign accept     = (state == IDLE) && ReqValid;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    ReqReady   = 1'b0;
    RspValid   = 1'b0;
    Busy       = 1'b1;
    AluA       = '0;
    AluB       = '0;
    AluOp      = '0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        Busy     = 1'b0;
        if (ReqValid) begin
          if (req_single)                    next_state = EXEC;
          else if (req_shift && ReqShamt != '0) next_state = SHIFT;
          else                               next_state = DONE;
        end
      end
      EXEC: begin
        AluA       = a_reg;
        AluB       = b_reg;
        AluOp      = op_reg;
        next_state = DONE;
      end
      SHIFT: begin
        AluA  = acc;
        AluB  = b_reg;
        AluOp = op_reg;
        if (cnt == SHAMT_W'(1)) next_state = DONE;
      end
      DONE: begin
        RspValid = 1'b1;
        if (RspReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Response registers hold their last value until the next result is produced.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      acc     <= '0;
      cnt     <= '0;
      RspOut  <= '0;
      RspZero <= 1'b0;
      RspErr  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg  <= ReqA;
        b_reg  <= ReqB;
        op_reg <= ReqOp;
        acc    <= ReqA;
        cnt    <= ReqShamt;
        if (!req_single && !req_shift) begin
          RspOut  <= '0;
          RspZero <= 1'b0;
          RspErr  <= 1'b1;
        end else if (req_shift && ReqShamt == '0) begin
          RspOut  <= ReqA;
          RspZero <= (ReqA == '0);
          RspErr  <= 1'b0;
        end
      end
      if (state == EXEC) begin
        RspOut  <= AluOut;
        RspZero <= AluZero;
        RspErr  <= 1'b0;
      end
      if (state == SHIFT) begin
        acc <= AluOut;
        cnt <= cnt - 1'b1;
        if (cnt == SHAMT_W'(1)) begin
          RspOut  <= AluOut;
          RspZero <= AluZero;
          RspErr  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a 1-bit-shift ALU model closes the loop and a
// whole-operation reference model predicts result, flags, latency and ALU activity.
module tb_alu_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid, ReqReady;
  logic [31:0] ReqA, ReqB;
  logic [3:0]  ReqOp;
  logic [4:0]  ReqShamt;
  logic        RspValid, RspReady;
  logic [31:0] RspOut;
  logic        RspZero, RspErr, Busy;
  logic [31:0] AluA, AluB, alu_out;
  logic [3:0]  AluOp;
  logic        alu_zero;

  int compared   = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  alu_seq_ctrl #(.SHAMT_W(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA(ReqA), .ReqB(ReqB), .ReqOp(ReqOp), .ReqShamt(ReqShamt),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspOut(RspOut), .RspZero(RspZero), .RspErr(RspErr), .Busy(Busy),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
    .AluOut(alu_out), .AluZero(alu_zero)
  );

  // Single-cycle ALU: shift/rotate by one bit per pass.
  always_comb begin
    alu_out = '0;
    case (AluOp)
      4'b0000: alu_out = AluA + AluB;
      4'b0001: alu_out = AluA - AluB;
      4'b0010: alu_out = AluA & AluB;
      4'b0011: alu_out = AluA | AluB;
      4'b0100: alu_out = ~AluA;
      4'b1000: alu_out = {AluA[31], AluA[31:1]};
      4'b1010: alu_out = {1'b0, AluA[31:1]};
      4'b1001: alu_out = {AluA[30:0], 1'b0};
      4'b1100: alu_out = {AluA[30:0], AluA[31]};
      4'b1101: alu_out = {AluA[0], AluA[31:1]};
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: full-distance shifts in one step.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic [4:0] s, output logic [31:0] o, output logic z,
                                output logic e, output int lat, output int alu_cycles);
    e = 1'b0;
    lat = 2;
    alu_cycles = 1;
    case (op)
      4'b0000: o = a + b;
      4'b0001: o = a - b;
      4'b0010: o = a & b;
      4'b0011: o = a | b;
      4'b0100: o = ~a;
      4'b1000: o = 32'($signed(a) >>> s);
      4'b1010: o = a >> s;
      4'b1001: o = a << s;
      4'b1100: o = (s == 0) ? a : ((a << s) | (a >> (32 - int'(s))));
      4'b1101: o = (s == 0) ? a : ((a >> s) | (a << (32 - int'(s))));
      default: begin o = '0; e = 1'b1; end
    endcase
    if (op[3] && !e) begin
      lat = int'(s) + 1;
      alu_cycles = int'(s);
    end
    if (e) begin
      lat = 1;
      alu_cycles = 0;
    end
    z = !e && (o == '0);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_rsp_valid"}, RspValid, 0);
    check({tag, "_rsp_out"},   RspOut,   0);
    check({tag, "_rsp_zero"},  RspZero,  0);
    check({tag, "_rsp_err"},   RspErr,   0);
    check({tag, "_busy"},      Busy,     0);
    check({tag, "_req_ready"}, ReqReady, 1);
    check({tag, "_alu"}, {AluA | AluB} | {28'd0, AluOp}, 0);
  endtask

  // Called at a negedge with the controller idle.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [4:0] s, input int bp);
    logic [31:0] eo, first_a, first_b;
    logic        ez, ee;
    int          elat, ealu, lat, alu_cyc;
    model(a, b, op, s, eo, ez, ee, elat, ealu);
    first_a = '0;
    first_b = '0;
    check("req_ready_idle", ReqReady, 1);
    ReqValid = 1'b1; ReqA = a; ReqB = b; ReqOp = op; ReqShamt = s;
    @(negedge Clk);
    ReqValid = 1'b0; ReqA = $urandom; ReqB = $urandom; ReqOp = 4'($urandom); ReqShamt = 5'($urandom);
    check("req_ready_after_accept", ReqReady, 0);
    lat = 1;
    alu_cyc = 0;
    while (!RspValid && lat < 40) begin
      if (AluOp == op) alu_cyc++;
      if (lat == 1) begin first_a = AluA; first_b = AluB; end
      RspReady = 1'($urandom);
      @(negedge Clk);
      lat++;
    end
    RspReady = 1'b0;
    check("latency", lat, elat);
    check("rsp_out", RspOut, eo);
    check("rsp_zero", RspZero, ez);
    check("rsp_err", RspErr, ee);
    check("alu_idle_in_done", {AluA | AluB} | {28'd0, AluOp}, 0);
    if (op != 4'b0000) check("alu_op_cycles", alu_cyc, ealu);
    if (ealu > 0) begin
      check("alu_a_first", first_a, a);
      check("alu_b_first", first_b, b);
    end
    for (int i = 0; i < bp; i++) begin
      ReqValid = 1'($urandom); ReqA = $urandom; ReqOp = 4'($urandom); ReqShamt = 5'($urandom);
      @(negedge Clk);
      check("bp_valid", RspValid, 1);
      check("bp_out", RspOut, eo);
      check("bp_flags", {30'd0, RspZero, RspErr}, {30'd0, ez, ee});
      check("bp_req_ready", ReqReady, 0);
    end
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    ReqValid = 1'b0;
    check("post_rsp_valid", RspValid, 0);
    check("post_req_ready", ReqReady, 1);
    check("post_busy", Busy, 0);
  endtask

  initial begin
    static logic [3:0] ops[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD};
    logic [3:0] op;
    logic [4:0] s;
    int         saw_valid;

    Reset = 1'b1;
    ReqValid = 1'b0; ReqA = '0; ReqB = '0; ReqOp = '0; ReqShamt = '0;
    RspReady = 1'b0;
    @(negedge Clk);
    check_reset_values("reset");
    Reset = 1'b0;
    @(negedge Clk);

    do_req(32'd5, 32'd7, 4'b0000, 5'd3, 0);
    do_req(32'd5, 32'd5, 4'b0001, 5'd0, 0);
    do_req(32'h0000_0001, 32'h0, 4'b1001, 5'd4, 0);
    do_req(32'h8000_0000, 32'h0, 4'b1000, 5'd31, 0);
    do_req(32'h8000_0001, 32'h0, 4'b1100, 5'd1, 0);
    do_req(32'h0, 32'h1234, 4'b1010, 5'd0, 0);
    do_req(32'hDEAD_BEEF, 32'h1, 4'b0101, 5'd7, 0);
    do_req(32'hF0F0_0000, 32'h0F0F_1234, 4'b0011, 5'd0, 3);
    do_req(32'h1234_5678, 32'h0, 4'b1101, 5'd8, 0);

    // Abort a long shift at its fifth iteration.
    ReqValid = 1'b1; ReqA = 32'h0000_0001; ReqB = '0; ReqOp = 4'b1001; ReqShamt = 5'd20;
    @(negedge Clk);
    ReqValid = 1'b0;
    repeat (4) @(negedge Clk);
    check("abort_in_shift", AluOp, 4'b1001);
    #2 Reset = 1'b1;
    #1 check_reset_values("abort");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    saw_valid = 0;
    repeat (30) begin
      @(negedge Clk);
      if (RspValid) saw_valid++;
    end
    check("abort_no_response", saw_valid, 0);
    do_req(32'd100, 32'hFFFF_FFFF, 4'b0000, 5'd0, 1);

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0:       s = 5'd0;
        1:       s = 5'd31;
        default: s = 5'($urandom);
      endcase
      do_req($urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, op, s, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
